// File: rtl/sand_pkg.sv
// Shared types and defaults for the sand grid brush painter.
package sand_pkg;

   localparam int GRID_W_DEF = 160;
   localparam int GRID_H_DEF = 120;
   localparam int ADDR_W_DEF = 15;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SAND  = 2'd1,
      WALL  = 2'd2,
      WATER = 2'd3
   } cell_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] radius;
      cell_t      cell_type;
   } brush_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } brush_state_t;

   // Magnitude of a scan offset; offsets never exceed +/-255 so 9 bits suffice.
   function automatic logic [8:0] abs10(input logic signed [9:0] v);
      logic signed [9:0] m;
      if (v < 10'sd0) begin
         m = -v;
      end else begin
         m = v;
      end
      return m[8:0];
   endfunction

endpackage

// File: rtl/sand_brush_hit.sv
// Decides whether a scan position lies inside the brush circle and on the grid.
module sand_brush_hit
   import sand_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  logic signed [9:0] dx,
   input  logic signed [9:0] dy,
   input  logic        [7:0] r,
   input  logic signed [9:0] cx,
   input  logic signed [9:0] cy,
   output logic              hit
);

   localparam logic signed [9:0] GW_S = 10'(GRID_W);
   localparam logic signed [9:0] GH_S = 10'(GRID_H);

   logic [16:0] dx_sq_s;
   logic [16:0] dy_sq_s;
   logic [16:0] dist_sq_s;
   logic [16:0] r_sq_s;
   logic        in_circle_s;
   logic        on_grid_s;

   // Squared distance against squared radius, plus grid clipping of the cell.
   always_comb begin
      dx_sq_s     = 17'(abs10(dx)) * 17'(abs10(dx));
      dy_sq_s     = 17'(abs10(dy)) * 17'(abs10(dy));
      dist_sq_s   = dx_sq_s + dy_sq_s;
      r_sq_s      = 17'(r) * 17'(r);
      in_circle_s = (dist_sq_s <= r_sq_s);
      on_grid_s   = (cx >= 10'sd0) && (cx < GW_S) && (cy >= 10'sd0) && (cy < GH_S);
      hit         = in_circle_s && on_grid_s;
   end

endmodule

// File: rtl/sand_brush_painter.sv
// Stamps a filled circle of one cell type into the grid RAM, one write per hit cell.
module sand_brush_painter
   import sand_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_x,
   input  logic [7:0]        cmd_y,
   input  logic [7:0]        cmd_radius,
   input  logic [1:0]        cmd_type,
   output logic              mem_req,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   brush_state_t      state_r;
   brush_state_t      state_next_s;
   brush_cmd_t        cmd_r;
   logic signed [9:0] dx_r;
   logic signed [9:0] dy_r;
   logic signed [9:0] r_s;
   logic signed [9:0] cx_s;
   logic signed [9:0] cy_s;
   logic [ADDR_W-1:0] addr_s;
   logic              hit_s;
   logic              last_s;
   logic              off_grid_s;
   logic              accept_s;
   logic              reject_s;
   logic              issue_s;
   logic              advance_s;

   logic              cmd_ready_r;
   logic              mem_req_r;
   logic [ADDR_W-1:0] mem_addr_r;
   cell_t             mem_data_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;

   sand_brush_hit #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_hit (
      .dx  (dx_r),
      .dy  (dy_r),
      .r   (cmd_r.radius),
      .cx  (cx_s),
      .cy  (cy_s),
      .hit (hit_s)
   );

   // Current cell coordinates, end-of-scan detection, command range check and cell address.
   always_comb begin
      r_s        = $signed({2'b00, cmd_r.radius});
      cx_s       = $signed({2'b00, cmd_r.x}) + dx_r;
      cy_s       = $signed({2'b00, cmd_r.y}) + dy_r;
      last_s     = (dx_r == r_s) && (dy_r == r_s);
      off_grid_s = ({1'b0, cmd_x} >= 9'(GRID_W)) || ({1'b0, cmd_y} >= 9'(GRID_H));
      addr_s     = ADDR_W'(cy_s[8:0]) * ADDR_W'(GRID_W) + ADDR_W'(cx_s[8:0]);
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      reject_s     = 1'b0;
      issue_s      = 1'b0;
      advance_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               if (off_grid_s) begin
                  reject_s     = 1'b1;
                  state_next_s = ST_IDLE;
               end else begin
                  accept_s     = 1'b1;
                  state_next_s = ST_SCAN;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (hit_s) begin
               issue_s      = 1'b1;
               state_next_s = ST_WRITE;
            end else begin
               advance_s = 1'b1;
               if (last_s) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_SCAN;
               end
            end
         end
         ST_WRITE: begin
            if (mem_ready) begin
               advance_s = 1'b1;
               if (last_s) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_SCAN;
               end
            end else begin
               state_next_s = ST_WRITE;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Command latch and row-major scan position (dx fastest, wrapping into dy).
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_r <= '{x: 8'd0, y: 8'd0, radius: 8'd0, cell_type: EMPTY};
         dx_r  <= 10'sd0;
         dy_r  <= 10'sd0;
      end else begin
         if (accept_s || reject_s) begin
            cmd_r <= '{x: cmd_x, y: cmd_y, radius: cmd_radius, cell_type: cell_t'(cmd_type)};
         end
         if (accept_s) begin
            dx_r <= -$signed({2'b00, cmd_radius});
            dy_r <= -$signed({2'b00, cmd_radius});
         end else if (advance_s) begin
            if (dx_r == r_s) begin
               dx_r <= -r_s;
               dy_r <= dy_r + 10'sd1;
            end else begin
               dx_r <= dx_r + 10'sd1;
            end
         end
      end
   end

   // Registered handshake and status outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready_r <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_addr_r  <= '0;
         mem_data_r  <= EMPTY;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         cmd_ready_r <= (state_next_s == ST_IDLE);
         mem_req_r   <= (state_next_s == ST_WRITE);
         busy_r      <= (state_next_s != ST_IDLE);
         done_r      <= (state_next_s == ST_DONE);
         error_r     <= reject_s;
         if (issue_s) begin
            mem_addr_r <= addr_s;
            mem_data_r <= cmd_r.cell_type;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign mem_req   = mem_req_r;
   assign mem_addr  = mem_addr_r;
   assign mem_data  = mem_data_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;

endmodule

// File: tb/tb_sand_brush_painter.sv
// Scoreboard bench for sand_brush_painter: expected writes queued at stimulus, checked by a monitor.
module tb_sand_brush_painter;
   import sand_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x;
   logic [7:0]  cmd_y;
   logic [7:0]  cmd_radius;
   logic [1:0]  cmd_type;
   logic        mem_req;
   logic        mem_ready;
   logic [14:0] mem_addr;
   logic [1:0]  mem_data;
   logic        busy;
   logic        done;
   logic        error;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   stall_len = 0;
   int   stall_cnt = 0;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   busy_cnt = 0;
   int   rise_cnt = 0;
   int   last_done_cyc = 0;
   int   last_rise_cyc = 0;
   logic prev_req = 1'b0;
   logic prev_ready = 1'b0;
   logic prev_done = 1'b0;
   logic prev_err = 1'b0;
   logic [14:0] prev_addr = 15'd0;
   logic [1:0]  prev_data = 2'd0;

   always #5 clk = ~clk;

   sand_brush_painter dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_radius (cmd_radius),
      .cmd_type   (cmd_type),
      .mem_req    (mem_req),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int addr, input int data);
      exp_q.push_back('{addr: addr, data: data});
   endtask

   // Cycle counter.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Arbiter model: optionally holds mem_ready low for stall_len cycles per request.
   initial begin
      mem_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_len == 0) begin
            mem_ready = 1'b1;
         end else if (mem_req) begin
            if (stall_cnt < stall_len) begin
               mem_ready = 1'b0;
               stall_cnt++;
            end else begin
               mem_ready = 1'b1;
            end
         end else begin
            mem_ready = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   // Monitor: pops expected writes on handshake, checks stall stability and pulse widths.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (prev_req && !prev_ready) begin
            check("stall_req", mem_req, 1);
            check("stall_addr", mem_addr, prev_addr);
            check("stall_data", mem_data, prev_data);
         end
         if (mem_req && !prev_req) begin
            rise_cnt++;
            last_rise_cyc = cyc;
         end
         if (mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", mem_addr, mon_e.addr);
               check("wr_data", mem_data, mon_e.data);
            end
         end
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check("done_one_cycle", prev_done, 0);
         end
         if (error) begin
            err_cnt++;
            check("error_one_cycle", prev_err, 0);
         end
         if (busy) begin
            busy_cnt++;
            check("ready_while_busy", cmd_ready, 0);
         end
         if (mem_req) begin
            check("req_implies_busy", busy, 1);
         end
      end
      prev_req   = reset ? 1'b0 : mem_req;
      prev_ready = reset ? 1'b0 : mem_ready;
      prev_done  = reset ? 1'b0 : done;
      prev_err   = reset ? 1'b0 : error;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
   end

   // Presents a command once cmd_ready is seen; returns the cycle in which it was offered.
   task automatic send_cmd(input int x, input int y, input int r, input int t, output int acc);
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 300) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!cmd_ready) begin
         check("cmd_ready_timeout", cmd_ready, 1);
      end
      cmd_valid  = 1'b1;
      cmd_x      = 8'(x);
      cmd_y      = 8'(y);
      cmd_radius = 8'(r);
      cmd_type   = 2'(t);
      acc        = cyc;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      int n;
      n = 0;
      while (done_cnt <= base && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_timeout", done_cnt > base, 1);
   endtask

   initial begin
      int acc;
      int b_done;
      int b_busy;
      int b_err;
      int b_rise;
      int n;

      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_x      = 8'd0;
      cmd_y      = 8'd0;
      cmd_radius = 8'd0;
      cmd_type   = 2'd0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_mem_addr", mem_addr, 0);
      check("idle_mem_data", mem_data, 0);
      check("idle_done", done, 0);
      check("idle_error", error, 0);

      // Centre (10,10) r=1 SAND, mem_ready always high.
      push(1450, 1); push(1609, 1); push(1610, 1); push(1611, 1); push(1770, 1);
      b_done = done_cnt; b_busy = busy_cnt;
      send_cmd(10, 10, 1, 1, acc);
      wait_done(b_done, 200);
      repeat (2) @(posedge clk);
      #1;
      check("t1_done_count", done_cnt - b_done, 1);
      check("t1_busy_cycles", busy_cnt - b_busy, 15);
      check("t1_all_written", exp_q.size(), 0);

      // Corner clip at (0,0) r=1.
      push(0, 1); push(1, 1); push(160, 1);
      b_done = done_cnt;
      send_cmd(0, 0, 1, 1, acc);
      wait_done(b_done, 200);
      repeat (2) @(posedge clk);
      #1;
      check("t2_done_count", done_cnt - b_done, 1);
      check("t2_all_written", exp_q.size(), 0);

      // Radius 0 at (5,7) WALL.
      push(1125, 2);
      b_done = done_cnt; b_rise = rise_cnt;
      send_cmd(5, 7, 0, 2, acc);
      wait_done(b_done, 50);
      repeat (2) @(posedge clk);
      #1;
      check("t3_req_latency", last_rise_cyc - acc, 2);
      check("t3_done_latency", last_done_cyc - acc, 3);
      check("t3_write_count", rise_cnt - b_rise, 1);
      check("t3_all_written", exp_q.size(), 0);

      // Backpressure: mem_ready low for 4 cycles on every request.
      stall_len = 4;
      push(1450, 1); push(1609, 1); push(1610, 1); push(1611, 1); push(1770, 1);
      b_done = done_cnt; b_busy = busy_cnt;
      send_cmd(10, 10, 1, 1, acc);
      wait_done(b_done, 300);
      repeat (2) @(posedge clk);
      #1;
      stall_len = 0;
      check("t4_done_count", done_cnt - b_done, 1);
      check("t4_busy_cycles", busy_cnt - b_busy, 35);
      check("t4_all_written", exp_q.size(), 0);

      // Off-grid centre is rejected, then a valid command proceeds.
      b_done = done_cnt; b_err = err_cnt; b_rise = rise_cnt;
      send_cmd(200, 5, 2, 1, acc);
      repeat (4) @(posedge clk);
      #1;
      check("t5_error_count", err_cnt - b_err, 1);
      check("t5_no_done", done_cnt - b_done, 0);
      check("t5_no_write", rise_cnt - b_rise, 0);
      check("t5_ready_after_error", cmd_ready, 1);
      push(1125, 2);
      send_cmd(5, 7, 0, 2, acc);
      wait_done(b_done, 50);
      repeat (2) @(posedge clk);
      #1;
      check("t5_followup_written", exp_q.size(), 0);

      // Reset during the (stalled) third write of (10,10) r=1.
      stall_len = 4;
      push(1450, 1); push(1609, 1);
      b_rise = rise_cnt;
      send_cmd(10, 10, 1, 1, acc);
      n = 0;
      while ((rise_cnt - b_rise) < 3 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t6_third_write_seen", rise_cnt - b_rise, 3);
      b_done = done_cnt;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      stall_len = 0;
      @(posedge clk);
      #1;
      check("t6_mem_req", mem_req, 0);
      check("t6_busy", busy, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      repeat (10) @(posedge clk);
      #1;
      check("t6_no_done", done_cnt - b_done, 0);
      check("t6_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

endmodule
